// File: rtl/agc_gain_sequencer.sv
// Closed-loop AGC controller: measures the windowed peak magnitude of the scaler
// output and steps the scaler's shift ladder (attack down, hold-then-decay up).
module agc_gain_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int WINDOW_LOG2    = 10,
  parameter int HOLD_WINDOWS   = 4,
  parameter int SETTLE_SAMPLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  input  logic                         agc_enable,
  input  logic        [DATA_WIDTH-2:0] high_thresh,
  input  logic        [DATA_WIDTH-2:0] low_thresh,
  input  logic        [7:0]            manual_gain,
  input  logic                         manual_load,
  output logic        [7:0]            gain_control,
  output logic                         gain_update,
  output logic                         at_limit,
  output logic        [1:0]            agc_state
);

  localparam int MAG_W    = DATA_WIDTH - 1;
  localparam int HOLD_W   = $clog2(HOLD_WINDOWS + 1);
  localparam int SETTLE_W = $clog2(SETTLE_SAMPLES + 1);

  localparam logic [3:0]          IDX_UNITY   = 4'd7;
  localparam logic [3:0]          IDX_MAX     = 4'd14;
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_WINDOWS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  // Ladder index 0..14 (higher = more gain) to the scaler's shift code.
  function automatic logic [3:0] index_to_shift(input logic [3:0] idx);
    if (idx < IDX_UNITY)       return IDX_UNITY - idx;
    else if (idx == IDX_UNITY) return 4'd8;
    else                       return idx + 4'd1;
  endfunction

  function automatic logic [3:0] shift_to_index(input logic [3:0] code);
    if (code == 4'd0 || code == 4'd8) return IDX_UNITY;
    else if (code > 4'd8)             return code - 4'd1;
    else                              return IDX_UNITY - code;
  endfunction

  state_t                  state, state_n;
  logic [3:0]              index, index_n;
  logic [3:0]              mult, mult_n;
  logic [MAG_W-1:0]        peak, peak_n;
  logic [WINDOW_LOG2-1:0]  win_cnt, win_cnt_n;
  logic [HOLD_W-1:0]       hold_cnt, hold_cnt_n;
  logic [SETTLE_W-1:0]     settle_cnt, settle_cnt_n;
  logic [7:0]              gain_control_n;
  logic                    gain_update_n;
  logic                    at_limit_n;

  logic [DATA_WIDTH-1:0]   neg_sample;
  logic [MAG_W-1:0]        magnitude;

  // The most negative sample has no positive twin, so it saturates to full scale.
  always_comb begin
    neg_sample = -sample_in;
    if (!sample_in[DATA_WIDTH-1])     magnitude = sample_in[MAG_W-1:0];
    else if (neg_sample[DATA_WIDTH-1]) magnitude = '1;
    else                               magnitude = neg_sample[MAG_W-1:0];
  end

  always_comb begin
    // NOTE: every next-state variable gets its default first, so no path through
    // this block can leave one unassigned and infer a latch.
    state_n        = state;
    index_n        = index;
    mult_n         = mult;
    peak_n         = peak;
    win_cnt_n      = win_cnt;
    hold_cnt_n     = hold_cnt;
    settle_cnt_n   = settle_cnt;
    gain_control_n = gain_control;
    gain_update_n  = 1'b0;
    at_limit_n     = at_limit;

    if (manual_load) begin
      mult_n         = manual_gain[7:4];
      index_n        = shift_to_index(manual_gain[3:0]);
      gain_control_n = {mult_n, index_to_shift(index_n)};
      gain_update_n  = (gain_control_n != gain_control);
      hold_cnt_n     = '0;
      peak_n         = '0;
      win_cnt_n      = '0;
      settle_cnt_n   = '0;
      state_n        = agc_enable ? SETTLE : IDLE;
    end else if (!agc_enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_n   = MEASURE;
          peak_n    = '0;
          win_cnt_n = '0;
        end

        MEASURE: begin
          if (sample_valid) begin
            if (magnitude > peak) peak_n = magnitude;
            if (win_cnt == '1) state_n   = DECIDE;
            else               win_cnt_n = win_cnt + WINDOW_LOG2'(1);
          end
        end

        DECIDE: begin
          at_limit_n = 1'b0;
          if (peak >= high_thresh) begin
            hold_cnt_n = '0;
            if (index == 4'd0) at_limit_n = 1'b1;
            else               index_n    = index - 4'd1;
          end else if (peak < low_thresh) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt_n = '0;
              if (index == IDX_MAX) at_limit_n = 1'b1;
              else                  index_n    = index + 4'd1;
            end else begin
              hold_cnt_n = hold_cnt + HOLD_W'(1);
            end
          end else begin
            hold_cnt_n = '0;
          end

          if (index_n != index) begin
            gain_control_n = {mult, index_to_shift(index_n)};
            gain_update_n  = 1'b1;
            settle_cnt_n   = '0;
            state_n        = SETTLE;
          end else begin
            peak_n    = '0;
            win_cnt_n = '0;
            state_n   = MEASURE;
          end
        end

        SETTLE: begin
          if (sample_valid) begin
            if (settle_cnt == SETTLE_LAST) begin
              peak_n    = '0;
              win_cnt_n = '0;
              state_n   = MEASURE;
            end else begin
              settle_cnt_n = settle_cnt + SETTLE_W'(1);
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      index        <= IDX_UNITY;
      mult         <= '0;
      peak         <= '0;
      win_cnt      <= '0;
      hold_cnt     <= '0;
      settle_cnt   <= '0;
      gain_control <= 8'h08;
      gain_update  <= 1'b0;
      at_limit     <= 1'b0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples the
      // pre-edge values computed above, independent of statement order.
      state        <= state_n;
      index        <= index_n;
      mult         <= mult_n;
      peak         <= peak_n;
      win_cnt      <= win_cnt_n;
      hold_cnt     <= hold_cnt_n;
      settle_cnt   <= settle_cnt_n;
      gain_control <= gain_control_n;
      gain_update  <= gain_update_n;
      at_limit     <= at_limit_n;
    end
  end

  assign agc_state = state;

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Testbench for agc_gain_sequencer: window-level vector table, hand-written corner
// sequences, and randomized windows against a behavioural ladder model.
module tb_agc_gain_sequencer;

  localparam int DW     = 32;
  localparam int WL2    = 4;
  localparam int WIN    = 1 << WL2;
  localparam int HOLD   = 4;
  localparam int SETTLE = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     sample_in;
  logic              sample_valid;
  logic              agc_enable;
  logic [DW-2:0]     high_thresh;
  logic [DW-2:0]     low_thresh;
  logic [7:0]        manual_gain;
  logic              manual_load;
  logic [7:0]        gain_control;
  logic              gain_update;
  logic              at_limit;
  logic [1:0]        agc_state;

  agc_gain_sequencer #(
    .DATA_WIDTH    (DW),
    .WINDOW_LOG2   (WL2),
    .HOLD_WINDOWS  (HOLD),
    .SETTLE_SAMPLES(SETTLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .agc_enable  (agc_enable),
    .high_thresh (high_thresh),
    .low_thresh  (low_thresh),
    .manual_gain (manual_gain),
    .manual_load (manual_load),
    .gain_control(gain_control),
    .gain_update (gain_update),
    .at_limit    (at_limit),
    .agc_state   (agc_state)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (gain_update === 1'b1) pulse_cnt++;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Shift code for each ladder index 0..14.
  logic [3:0] shift_tab [15] = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd8,
                                 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  int         m_idx;
  int         m_hold;
  logic [3:0] m_mult;
  logic       m_limit;

  function automatic logic [7:0] model_gc();
    return {m_mult, shift_tab[m_idx]};
  endfunction

  function automatic longint mag(input logic [31:0] v);
    longint x;
    x = longint'($signed(v));
    if (x < 0) x = -x;
    if (x > 64'sh7FFF_FFFF) x = 64'sh7FFF_FFFF;
    return x;
  endfunction

  task automatic model_manual(input logic [7:0] g);
    m_mult = g[7:4];
    m_idx  = 7;
    for (int k = 0; k < 15; k++) if (shift_tab[k] == g[3:0]) m_idx = k;
    m_hold = 0;
  endtask

  task automatic model_decide(input longint pk, input longint hi, input longint lo,
                              output logic changed);
    int step;
    step = 0;
    if (pk >= hi) begin
      m_hold = 0;
      step   = -1;
    end else if (pk < lo) begin
      m_hold++;
      if (m_hold == HOLD) begin
        m_hold = 0;
        step   = 1;
      end
    end else begin
      m_hold = 0;
    end
    changed = 1'b0;
    m_limit = 1'b0;
    if (step != 0) begin
      if (m_idx + step < 0 || m_idx + step > 14) m_limit = 1'b1;
      else begin
        m_idx   = m_idx + step;
        changed = 1'b1;
      end
    end
  endtask

  task automatic feed(input logic [31:0] v, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      sample_in    = $urandom;
    end
    @(negedge clk);
    sample_in    = v;
    sample_valid = 1'b1;
  endtask

  // Leaves the bench at the negedge where the DUT sits in DECIDE.
  task automatic run_window(input logic [31:0] fill, input logic [31:0] last);
    for (int i = 0; i < WIN - 1; i++) feed(fill, 0);
    feed(last, 0);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic settle_out(input int max_gap);
    for (int i = 0; i < SETTLE; i++)
      feed(($urandom_range(1) != 0) ? 32'h8000_0000 : $urandom, $urandom_range(max_gap));
    @(negedge clk);
    sample_valid = 1'b0;
    #1;
    check("settle_exit_state", agc_state, 1);
  endtask

  task automatic manual(input logic [7:0] g, input logic en);
    @(negedge clk);
    sample_valid = 1'b0;
    manual_gain  = g;
    manual_load  = 1'b1;
    agc_enable   = en;
    @(negedge clk);
    manual_load = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [31:0] fill;
    logic [31:0] last;
    logic [30:0] hi;
    logic [30:0] lo;
    logic [7:0]  exp_gc;
    logic        exp_upd;
    logic        exp_lim;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          p0;
    int          p_exp;
    int          hi, lo, bound, cls, pos, sv;
    longint      pk;
    logic        changed;
    logic [7:0]  g, prev_gc;
    logic [31:0] v;

    // Window-level vectors from reset (ladder index 7, shift code 8).
    vecs[0]  = '{32'd50,  -32'sd2000, 31'd1000, 31'd100, 8'h01, 1'b1, 1'b0};
    vecs[1]  = '{32'd10,  32'd10,     31'd1000, 31'd100, 8'h01, 1'b0, 1'b0};
    vecs[2]  = '{32'd10,  -32'sd10,   31'd1000, 31'd100, 8'h01, 1'b0, 1'b0};
    vecs[3]  = '{-32'sd10, 32'd10,    31'd1000, 31'd100, 8'h01, 1'b0, 1'b0};
    vecs[4]  = '{32'd10,  32'd10,     31'd1000, 31'd100, 8'h08, 1'b1, 1'b0};
    vecs[5]  = '{32'd500, -32'sd500,  31'd1000, 31'd100, 8'h08, 1'b0, 1'b0};
    vecs[6]  = '{32'd10,  32'd10,     31'd1000, 31'd100, 8'h08, 1'b0, 1'b0};
    vecs[7]  = '{32'd10,  32'd10,     31'd1000, 31'd100, 8'h08, 1'b0, 1'b0};
    vecs[8]  = '{32'd10,  32'd10,     31'd1000, 31'd100, 8'h08, 1'b0, 1'b0};
    vecs[9]  = '{32'd10,  32'd999,    31'd1000, 31'd100, 8'h08, 1'b0, 1'b0};
    vecs[10] = '{32'd10,  32'd10,     31'd1000, 31'd100, 8'h08, 1'b0, 1'b0};
    vecs[11] = '{32'd10,  32'd1000,   31'd1000, 31'd100, 8'h01, 1'b1, 1'b0};
    vecs[12] = '{32'd99,  -32'sd99,   31'd1000, 31'd100, 8'h01, 1'b0, 1'b0};
    vecs[13] = '{32'd100, 32'd100,    31'd1000, 31'd100, 8'h01, 1'b0, 1'b0};
    vecs[14] = '{32'd60,  32'd60,     31'd50,   31'd10,  8'h02, 1'b1, 1'b0};

    rst          = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    agc_enable   = 1'b1;
    high_thresh  = 31'd1000;
    low_thresh   = 31'd100;
    manual_gain  = 8'h00;
    manual_load  = 1'b0;

    #2 rst = 1'b1;
    #1;
    check("reset_gain_control", gain_control, 8'h08);
    check("reset_gain_update", gain_update, 0);
    check("reset_at_limit", at_limit, 0);
    check("reset_state", agc_state, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      high_thresh = vecs[i].hi;
      low_thresh  = vecs[i].lo;
      p0 = pulse_cnt;
      run_window(vecs[i].fill, vecs[i].last);
      check($sformatf("vec%0d_decide_state", i), agc_state, 2);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_gain_control", i), gain_control, vecs[i].exp_gc);
      check($sformatf("vec%0d_gain_update", i), gain_update, vecs[i].exp_upd);
      check($sformatf("vec%0d_at_limit", i), at_limit, vecs[i].exp_lim);
      check($sformatf("vec%0d_next_state", i), agc_state, vecs[i].exp_upd ? 3 : 1);
      if (vecs[i].exp_upd) settle_out(1);
      check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_upd);
    end

    // Upper ladder limit: index 14 with four quiet windows.
    high_thresh = 31'd1000;
    low_thresh  = 31'd100;
    manual(8'h0F, 1'b1);
    check("load_0f_gain", gain_control, 8'h0F);
    check("load_0f_update", gain_update, 1);
    check("load_0f_state", agc_state, 3);
    settle_out(0);
    p0 = pulse_cnt;
    for (int w = 0; w < HOLD; w++) begin
      run_window(32'd10, 32'd10);
      @(negedge clk);
      #1;
      check($sformatf("upper_w%0d_gain", w), gain_control, 8'h0F);
      check($sformatf("upper_w%0d_at_limit", w), at_limit, (w == HOLD - 1) ? 1 : 0);
    end
    check("upper_no_pulse", pulse_cnt - p0, 0);

    // Asynchronous reset mid-window, observed before any clock edge.
    for (int i = 0; i < 5; i++) feed(32'd3000, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_gain_control", gain_control, 8'h08);
    check("midrst_gain_update", gain_update, 0);
    check("midrst_at_limit", at_limit, 0);
    check("midrst_state", agc_state, 0);
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b0;

    // Saturation: -2^31 reads as 2^31-1, which equals the ceiling.
    high_thresh = 31'h7FFF_FFFF;
    run_window(32'h8000_0000, 32'h8000_0000);
    @(negedge clk);
    #1;
    check("sat_gain_control", gain_control, 8'h01);
    check("sat_gain_update", gain_update, 1);
    settle_out(0);

    // Lower ladder limit and at_limit release.
    high_thresh = 31'd1000;
    manual(8'h07, 1'b1);
    check("load_07_gain", gain_control, 8'h07);
    settle_out(0);
    p0 = pulse_cnt;
    run_window(32'd2000, 32'd2000);
    @(negedge clk);
    #1;
    check("lower_gain", gain_control, 8'h07);
    check("lower_at_limit", at_limit, 1);
    check("lower_state", agc_state, 1);
    run_window(32'd500, 32'd500);
    @(negedge clk);
    #1;
    check("limit_release", at_limit, 0);
    check("lower_no_pulse", pulse_cnt - p0, 0);

    // manual_load in the DECIDE cycle of an attack window.
    manual(8'h09, 1'b1);
    settle_out(0);
    p0 = pulse_cnt;
    run_window(32'd2000, 32'd2000);
    manual_gain = 8'h30;
    manual_load = 1'b1;
    @(negedge clk);
    manual_load = 1'b0;
    #1;
    check("prio_gain_control", gain_control, 8'h38);
    check("prio_gain_update", gain_update, 1);
    check("prio_state", agc_state, 3);
    settle_out(0);
    check("prio_single_pulse", pulse_cnt - p0, 1);

    // Enable drop mid-window, then a fresh full window after re-enable.
    for (int i = 0; i < 5; i++) feed(32'd2000, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    agc_enable   = 1'b0;
    @(negedge clk);
    #1;
    check("disable_state", agc_state, 0);
    check("disable_gain", gain_control, 8'h38);
    repeat (3) @(negedge clk);
    agc_enable = 1'b1;
    @(negedge clk);
    #1;
    check("reenable_state", agc_state, 1);
    for (int i = 0; i < WIN - 1; i++) feed(32'd2000, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    #1;
    check("fresh_window_state", agc_state, 1);
    feed(32'd2000, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    #1;
    check("fresh_decide_state", agc_state, 2);
    @(negedge clk);
    #1;
    check("fresh_gain_control", gain_control, 8'h31);
    settle_out(0);

    // manual_load while disabled lands in IDLE.
    manual(8'h3A, 1'b0);
    check("manual_idle_gain", gain_control, 8'h3A);
    check("manual_idle_update", gain_update, 1);
    check("manual_idle_state", agc_state, 0);

    // Randomized windows against the ladder model.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    agc_enable = 1'b1;
    m_idx   = 7;
    m_mult  = 4'h0;
    m_hold  = 0;
    m_limit = 1'b0;
    prev_gc = model_gc();
    p0      = pulse_cnt;
    p_exp   = 0;

    for (int w = 0; w < 48; w++) begin
      if (w % 12 == 0) begin
        g = 8'($urandom);
        model_manual(g);
        manual(g, 1'b1);
        changed = (model_gc() != prev_gc);
        if (changed) p_exp++;
        prev_gc = model_gc();
        check($sformatf("rnd%0d_load_gain", w), gain_control, model_gc());
        check($sformatf("rnd%0d_load_update", w), gain_update, changed);
        settle_out(2);
      end

      hi    = $urandom_range(3000, 50);
      lo    = $urandom_range(hi - 1, 1);
      cls   = $urandom_range(9);
      bound = (cls < 7) ? lo - 1 : hi + 300;
      pos   = $urandom_range(WIN - 1);
      pk    = 0;
      for (int s = 0; s < WIN; s++) begin
        sv = int'($urandom_range(2 * bound)) - bound;
        v  = (cls == 9 && s == pos) ? 32'h8000_0000 : 32'(sv);
        if (mag(v) > pk) pk = mag(v);
        if (s == WIN - 1) begin
          high_thresh = 31'(hi);
          low_thresh  = 31'(lo);
        end else if ($urandom_range(3) == 0) begin
          high_thresh = 31'($urandom);
          low_thresh  = 31'($urandom);
        end
        feed(v, $urandom_range(2));
      end
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      #1;
      model_decide(pk, hi, lo, changed);
      if (changed) p_exp++;
      prev_gc = model_gc();
      check($sformatf("rnd%0d_gain", w), gain_control, model_gc());
      check($sformatf("rnd%0d_update", w), gain_update, changed);
      check($sformatf("rnd%0d_at_limit", w), at_limit, m_limit);
      check($sformatf("rnd%0d_state", w), agc_state, changed ? 3 : 1);
      if (changed) settle_out(2);
    end
    check("rnd_total_pulses", pulse_cnt - p0, p_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
